// File: rtl/ventilacao_cascata_param_if.sv
// ventilacao_cascata_param_if: bundles the sensor/ack inputs and the damper/alarm outputs of the controller.
// The master modport drives the sensors and ack. The slave modport is the controller side.
interface ventilacao_cascata_param_if #(
   parameter int N_ZONAS = 6,
   parameter int W       = 4
);
   logic [N_ZONAS*W-1:0] pressoes;
   logic                 ack;
   logic [N_ZONAS-2:0]   dampers;
   logic                 perda_depressao;
   logic                 alarme_sonoro;
   logic                 alarme_luz;
   logic [1:0]           estado;
   logic [N_ZONAS-1:0]   falha_sensor;
   modport master (
      output pressoes, ack,
      input  dampers, perda_depressao, alarme_sonoro, alarme_luz, estado, falha_sensor
   );
   modport slave (
      input  pressoes, ack,
      output dampers, perda_depressao, alarme_sonoro, alarme_luz, estado, falha_sensor
   );
endinterface

// File: rtl/ventilacao_cascata_param.sv
// ventilacao_cascata_param: debounced inter-zone dampers plus a latched alarm FSM for a chain of depressurised zones.
// Optional sensor rail-fault detection is enabled with VENT_FALHA_SENSOR_EN.
module ventilacao_cascata_param #(
   parameter int N_ZONAS   = 6,
   parameter int W         = 4,
   parameter int MARGEM    = 0,
   parameter int DEB       = 4,
   parameter int ALARM_CYC = 16
) (
   input logic clk,
   input logic rst,
   ventilacao_cascata_param_if.slave bus
);
   localparam int CW = DEB > 1 ? $clog2(DEB) : 1;
   localparam int TW = $clog2(ALARM_CYC + 1);
   localparam logic signed [W:0] MARGEM_X = (W+1)'(MARGEM);
   typedef enum logic [1:0] {NORMAL, ALERTA, ALARME, RECONHECIDO} estado_t;
   logic [N_ZONAS-1:0] w_neg, w_rail, r_falha;
   logic [N_ZONAS-2:0] w_dampers;
   logic               r_perda, r_perda_d, w_anormal, w_subida;
   estado_t            r_estado, w_estado_nx;
   logic [TW-1:0]      r_tmr, w_tmr_nx;
   for (genvar k = 0; k < N_ZONAS; k++) begin : g_zona
      assign w_neg[k] = bus.pressoes[k*W+W-1];
`ifdef VENT_FALHA_SENSOR_EN
      assign w_rail[k] = bus.pressoes[k*W +: W] == {1'b1, {(W-1){1'b0}}};
`else
      assign w_rail[k] = 1'b0;
`endif
   end
   for (genvar i = 0; i < N_ZONAS-1; i++) begin : g_damper
      logic signed [W:0] w_a, w_b;
      logic              w_want, r_d;
      logic [CW-1:0]     r_c;
      // sign-extended by one bit so p[i]+MARGEM can never wrap
      assign w_a = $signed({bus.pressoes[i*W+W-1], bus.pressoes[i*W +: W]});
      assign w_b = $signed({bus.pressoes[(i+1)*W+W-1], bus.pressoes[(i+1)*W +: W]});
      assign w_want = !(w_neg[i] & w_neg[i+1] & (w_a + MARGEM_X > w_b));
      assign w_dampers[i] = r_d;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            r_d <= 1'b1;
            r_c <= '0;
         end else if (w_rail[i] | w_rail[i+1]) begin
            r_d <= 1'b1;
            r_c <= '0;
         end else if (w_want == r_d) r_c <= '0;
         else if (r_c == CW'(DEB-1)) begin
            r_d <= w_want;
            r_c <= '0;
         end else r_c <= r_c + CW'(1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_perda   <= 1'b0;
         r_perda_d <= 1'b0;
         r_falha   <= '0;
      end else begin
         r_perda   <= ~&w_neg;
         r_perda_d <= r_perda;
         r_falha   <= w_rail;
      end
   assign w_anormal = ~&w_dampers | r_perda | |r_falha;
   assign w_subida  = r_perda & ~r_perda_d;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_estado <= NORMAL;
         r_tmr    <= '0;
      end else begin
         r_estado <= w_estado_nx;
         r_tmr    <= w_tmr_nx;
      end
   always_comb begin
      w_estado_nx = r_estado;
      w_tmr_nx    = r_tmr;
      case (r_estado)
         NORMAL: if (w_anormal) begin
            w_estado_nx = ALERTA;
            w_tmr_nx    = TW'(1);
         end
         ALERTA:
            if (!w_anormal) w_estado_nx = NORMAL;
            else if (r_tmr == TW'(ALARM_CYC)) w_estado_nx = ALARME;
            else w_tmr_nx = r_tmr + TW'(1);
         ALARME: if (bus.ack) w_estado_nx = w_anormal ? RECONHECIDO : NORMAL;
         default:
            if (!w_anormal) w_estado_nx = NORMAL;
            else if (w_subida) w_estado_nx = ALARME;
      endcase
   end
   always_comb begin
      bus.alarme_sonoro = r_estado == ALARME;
      bus.alarme_luz    = r_estado == ALARME || r_estado == RECONHECIDO;
   end
   assign bus.dampers         = w_dampers;
   assign bus.perda_depressao = r_perda;
   assign bus.estado          = r_estado;
   assign bus.falha_sensor    = r_falha;
endmodule

// File: tb/tb_ventilacao_cascata_param.sv
// tb_ventilacao_cascata_param: directed table, corner sequences and randomized run against a reference model.
// Observed word = {dampers[1:0], perda, sonoro, luz, estado[1:0], falha[2:0]}.
module tb_ventilacao_cascata_param;
   localparam int MARGEM = 1, DEB = 2, ALARM_CYC = 3;
`ifdef VENT_FALHA_SENSOR_EN
   localparam bit FALHA_EN = 1'b1;
`else
   localparam bit FALHA_EN = 1'b0;
`endif
   // pressures packed {p2,p1,p0}
   localparam logic [11:0] P_OK = 12'hEB9, P_INV = 12'hE9B, P_LOSS = 12'h1B9, P_LINV = 12'h19B;
   localparam logic [11:0] P_EDGE = 12'hEBA, P_EDGE_INV = 12'hEAA, P_RAIL = 12'hE8B;
   localparam logic [9:0] R_OK   = 10'b11_0_0_0_00_000, D10    = 10'b10_0_0_0_00_000;
   localparam logic [9:0] A10    = 10'b10_0_0_0_01_000, ALM10  = 10'b10_0_1_1_10_000;
   localparam logic [9:0] ALM11  = 10'b11_0_1_1_10_000, L0     = 10'b11_1_0_0_00_000;
   localparam logic [9:0] L1     = 10'b11_1_0_0_01_000, LALM   = 10'b11_1_1_1_10_000;
   localparam logic [9:0] LREC   = 10'b11_1_0_1_11_000, REC11  = 10'b11_0_0_1_11_000;
   localparam logic [9:0] REC10  = 10'b10_0_0_1_11_000, REC10L = 10'b10_1_0_1_11_000;
   localparam logic [9:0] ALM10L = 10'b10_1_1_1_10_000;
   typedef struct {
      logic [11:0] p;
      logic        a;
      logic [9:0]  e;
   } vec_t;
   logic clk, rst;
   int   n_vec, n_err;
   vec_t tbl[31];
   ventilacao_cascata_param_if #(.N_ZONAS(3), .W(4)) bus ();
   ventilacao_cascata_param #(.N_ZONAS(3), .W(4), .MARGEM(MARGEM), .DEB(DEB), .ALARM_CYC(ALARM_CYC)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   wire logic [9:0] obs = {bus.dampers, bus.perda_depressao, bus.alarme_sonoro, bus.alarme_luz, bus.estado, bus.falha_sensor};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // reference model state: damper positions, run length of disagreeing samples, alarm state 0..3
   bit       m_damp[2];
   int       m_run[2];
   bit       m_perda, m_perda_prev;
   int       m_est, m_tmr;
   bit [2:0] m_falha;
   function automatic int zv(input logic [11:0] p, input int k);
      logic signed [3:0] t;
      t = p[k*4 +: 4];
      return int'(t);
   endfunction
   task automatic model_reset();
      m_damp = '{1'b1, 1'b1};
      m_run = '{0, 0};
      m_perda = 0;
      m_perda_prev = 0;
      m_est = 0;
      m_tmr = 0;
      m_falha = '0;
   endtask
   task automatic model_edge(input logic [11:0] p, input logic a);
      int z[3];
      bit an, ri, want;
      for (int k = 0; k < 3; k++) z[k] = zv(p, k);
      an = !m_damp[0] || !m_damp[1] || m_perda || (m_falha != 0);
      ri = m_perda && !m_perda_prev;
      if (m_est == 0) begin
         if (an) begin m_est = 1; m_tmr = 1; end
      end else if (m_est == 1) begin
         if (!an) m_est = 0;
         else if (m_tmr == ALARM_CYC) m_est = 2;
         else m_tmr++;
      end else if (m_est == 2) begin
         if (a) m_est = an ? 3 : 0;
      end else begin
         if (!an) m_est = 0;
         else if (ri) m_est = 2;
      end
      for (int i = 0; i < 2; i++) begin
         want = !(z[i] < 0 && z[i+1] < 0 && z[i] + MARGEM > z[i+1]);
         if (FALHA_EN && (z[i] == -8 || z[i+1] == -8)) begin
            m_damp[i] = 1;
            m_run[i] = 0;
         end else if (want != m_damp[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_damp[i] = want; m_run[i] = 0; end
         end else m_run[i] = 0;
      end
      m_perda_prev = m_perda;
      m_perda = z[0] >= 0 || z[1] >= 0 || z[2] >= 0;
      for (int k = 0; k < 3; k++) m_falha[k] = FALHA_EN && z[k] == -8;
   endtask
   function automatic logic [9:0] m_obs();
      return {m_damp[1], m_damp[0], m_perda, m_est == 2, m_est >= 2, 2'(m_est), m_falha};
   endfunction
   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask
   task automatic step(input logic [11:0] p, input logic a);
      bus.pressoes = p;
      bus.ack = a;
      @(posedge clk);
      #1;
      model_edge(p, a);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.pressoes = P_OK;
      bus.ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("reset", obs, R_OK);
      rst = 1'b0;
   endtask
   initial begin
      logic [11:0] p;
      int hold, c;
      n_vec = 0;
      n_err = 0;
      tbl = '{
         '{P_OK, 0, R_OK},    '{P_INV, 0, R_OK},   '{P_OK, 0, R_OK},    '{P_INV, 0, R_OK},
         '{P_INV, 0, D10},    '{P_INV, 0, A10},    '{P_INV, 0, A10},    '{P_INV, 0, A10},
         '{P_INV, 0, ALM10},  '{P_OK, 0, ALM10},   '{P_OK, 0, ALM11},   '{P_OK, 1, R_OK},
         '{P_OK, 1, R_OK},    '{P_LOSS, 0, L0},    '{P_LOSS, 0, L1},    '{P_LOSS, 0, L1},
         '{P_LOSS, 0, L1},    '{P_LOSS, 0, LALM},  '{P_LOSS, 1, LREC},  '{P_LOSS, 1, LREC},
         '{P_OK, 0, REC11},   '{P_OK, 0, R_OK},    '{P_INV, 0, R_OK},   '{P_INV, 0, D10},
         '{P_INV, 0, A10},    '{P_INV, 0, A10},    '{P_INV, 0, A10},    '{P_INV, 0, ALM10},
         '{P_INV, 1, REC10},  '{P_LINV, 0, REC10L}, '{P_LINV, 0, ALM10L}
      };
      do_reset();
      for (int r = 0; r < 31; r++) begin
         step(tbl[r].p, tbl[r].a);
         check($sformatf("row%0d", r), obs, tbl[r].e);
      end
      // asynchronous reset while latched in ALARME with damper0 closed
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", obs, R_OK);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      // margin boundary: -6+1 <= -5 keeps the damper open, -6 vs -6 closes it after DEB samples
      for (int k = 0; k < 3; k++) begin
         step(P_EDGE, 0);
         check("edge_ok", obs, R_OK);
      end
      step(P_EDGE_INV, 0);
      check("edge_inv1", obs, R_OK);
      step(P_EDGE_INV, 0);
      check("edge_inv2", obs, D10);
      do_reset();
      c = 0;
      while (c < 600) begin
         hold = $urandom_range(1, 6);
         for (int k = 0; k < 3; k++)
            p[k*4 +: 4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         for (int h = 0; h < hold && c < 600; h++, c++) begin
            step(p, $urandom_range(0, 7) == 0);
            check("rand", obs, m_obs());
         end
      end
      do_reset();
      step(P_RAIL, 0);
      check("rail_falha", {7'b0, bus.falha_sensor}, {7'b0, FALHA_EN ? 3'b010 : 3'b000});
      check("rail_dampers", {8'b0, bus.dampers}, 10'b11);
      for (int k = 0; k < 4; k++) begin
         step(P_RAIL, 0);
         check("rail_seq", obs, m_obs());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
